// File: rtl/ysyx_22040759_mem_arbiter.sv
// Two-requester memory arbiter: shares one bridge port between icache refill and dcache/LSU,
// holding each grant for a whole transaction and alternating priority on ties.
module ysyx_22040759_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_ram_ren,
  input  logic [AW-1:0]   icache_ram_raddr,
  output logic [DW-1:0]   ram_icache_rdata,
  output logic            icache_data_valid,
  input  logic            dcache_req,
  input  logic            dcache_wen,
  input  logic [AW-1:0]   dcache_addr,
  input  logic [DW-1:0]   dcache_wdata,
  input  logic [DW/8-1:0] dcache_wmask,
  output logic [DW-1:0]   dcache_rdata,
  output logic            dcache_ready,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_done,
  output logic            arb_busy
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, state_next;
  logic   last_grant, last_grant_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Requests are only looked at in IDLE; a grant is released solely by mem_done.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (icache_ram_ren && dcache_req) begin
          if (last_grant == GRANT_D) begin
            state_next      = IBUSY;
            last_grant_next = GRANT_I;
          end else begin
            state_next      = DBUSY;
            last_grant_next = GRANT_D;
          end
        end else if (icache_ram_ren) begin
          state_next = IBUSY;
        end else if (dcache_req) begin
          state_next = DBUSY;
        end
      end
      IBUSY:   if (mem_done) state_next = IDLE;
      DBUSY:   if (mem_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req           = 1'b0;
    mem_wen           = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    mem_wmask         = '0;
    icache_data_valid = 1'b0;
    ram_icache_rdata  = '0;
    dcache_ready      = 1'b0;
    dcache_rdata      = '0;
    case (state)
      IBUSY: begin
        mem_req  = 1'b1;
        mem_addr = icache_ram_raddr;
        if (mem_done) begin
          icache_data_valid = 1'b1;
          ram_icache_rdata  = mem_rdata;
        end
      end
      DBUSY: begin
        mem_req   = 1'b1;
        mem_wen   = dcache_wen;
        mem_addr  = dcache_addr;
        mem_wdata = dcache_wdata;
        mem_wmask = dcache_wmask;
        if (mem_done) begin
          dcache_ready = 1'b1;
          dcache_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the memory arbiter: a transaction-level owner model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_ysyx_22040759_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_ram_ren;
  logic [31:0] icache_ram_raddr;
  logic [63:0] ram_icache_rdata;
  logic        icache_data_valid;
  logic        dcache_req;
  logic        dcache_wen;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [7:0]  dcache_wmask;
  logic [63:0] dcache_rdata;
  logic        dcache_ready;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;
  logic        mem_done;
  logic        arb_busy;

  int errors = 0;
  int checks = 0;

  ysyx_22040759_mem_arbiter #(.AW(32), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .icache_ram_ren(icache_ram_ren), .icache_ram_raddr(icache_ram_raddr),
    .ram_icache_rdata(ram_icache_rdata), .icache_data_valid(icache_data_valid),
    .dcache_req(dcache_req), .dcache_wen(dcache_wen), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask),
    .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Model: who currently owns the port (0 none, 1 icache, 2 dcache) and who won the last tie.
  int owner = 0;
  int lastTieWinner = 2;
  bit modelOn = 0;

  always @(posedge clk) begin
    if (rst) begin
      owner = 0;
      lastTieWinner = 2;
      modelOn = 1;
    end else if (owner == 0) begin
      if (icache_ram_ren && dcache_req) begin
        owner = (lastTieWinner == 2) ? 1 : 2;
        lastTieWinner = owner;
      end else if (icache_ram_ren) owner = 1;
      else if (dcache_req) owner = 2;
    end else if (mem_done) begin
      owner = 0;
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("m.mem_req", mem_req, owner != 0);
      checkOutput("m.arb_busy", arb_busy, owner != 0);
      checkOutput("m.mem_wen", mem_wen, (owner == 2) ? dcache_wen : 1'b0);
      checkOutput("m.mem_addr", mem_addr, (owner == 1) ? icache_ram_raddr : (owner == 2) ? dcache_addr : 32'h0);
      checkOutput("m.mem_wdata", mem_wdata, (owner == 2) ? dcache_wdata : 64'h0);
      checkOutput("m.mem_wmask", mem_wmask, (owner == 2) ? dcache_wmask : 8'h0);
      checkOutput("m.icache_valid", icache_data_valid, (owner == 1) && mem_done);
      checkOutput("m.icache_rdata", ram_icache_rdata, ((owner == 1) && mem_done) ? mem_rdata : 64'h0);
      checkOutput("m.dcache_ready", dcache_ready, (owner == 2) && mem_done);
      checkOutput("m.dcache_rdata", dcache_rdata, ((owner == 2) && mem_done) ? mem_rdata : 64'h0);
    end
  end

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Count IDLE cycles until the port is granted (bounded).
  task automatic waitGrant(output int gap);
    gap = 0;
    while (!mem_req && gap < 20) begin
      gap++;
      applyStimulus();
    end
  endtask

  initial begin
    int gap;
    logic [7:0] order;
    logic [3:0] expOrder;
    rst = 1'b1;
    icache_ram_ren = 1'b0; icache_ram_raddr = 32'h0;
    dcache_req = 1'b0; dcache_wen = 1'b0; dcache_addr = 32'h0;
    dcache_wdata = 64'h0; dcache_wmask = 8'h0;
    mem_rdata = 64'h5555_AAAA_5555_AAAA; mem_done = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset arb_busy", arb_busy, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset icache_rdata", ram_icache_rdata, 0);

    // icache read, completion three cycles after the grant
    applyStimulus();
    icache_ram_ren = 1'b1; icache_ram_raddr = 32'h8000_0008;
    #1 checkOutput("i.req same cycle", mem_req, 0);
    applyStimulus();
    checkOutput("i.mem_req", mem_req, 1);
    checkOutput("i.mem_wen", mem_wen, 0);
    checkOutput("i.mem_addr", mem_addr, 64'h8000_0008);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    mem_done = 1'b1; mem_rdata = 64'h0000_0013_0000_0093;
    #1 checkOutput("i.valid", icache_data_valid, 1);
    checkOutput("i.rdata", ram_icache_rdata, 64'h0000_0013_0000_0093);
    applyStimulus();
    mem_done = 1'b0; icache_ram_ren = 1'b0;
    checkOutput("i.idle after done", arb_busy, 0);

    // dcache write
    dcache_req = 1'b1; dcache_wen = 1'b1; dcache_addr = 32'h8000_1000;
    dcache_wdata = 64'hDEAD_BEEF_0000_0001; dcache_wmask = 8'h0F;
    applyStimulus();
    checkOutput("d.mem_wen", mem_wen, 1);
    checkOutput("d.mem_addr", mem_addr, 64'h8000_1000);
    checkOutput("d.mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
    checkOutput("d.mem_wmask", mem_wmask, 8'h0F);
    applyStimulus();
    mem_done = 1'b1; mem_rdata = 64'h1234;
    #1 checkOutput("d.ready", dcache_ready, 1);
    checkOutput("d.no icache valid", icache_data_valid, 0);
    applyStimulus();
    mem_done = 1'b0; dcache_req = 1'b0; dcache_wen = 1'b0;
    applyStimulus();

    // Both requesting continuously: expect I, D, I, D with one IDLE cycle between grants
    icache_ram_raddr = 32'h8000_0100; dcache_addr = 32'h8000_2000;
    icache_ram_ren = 1'b1; dcache_req = 1'b1;
    expOrder = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      waitGrant(gap);
      checkOutput($sformatf("rr.gap%0d", t), gap, 1);
      order[t] = (mem_addr == 32'h8000_0100);
      checkOutput($sformatf("rr.grant%0d_is_icache", t), order[t], expOrder[3-t]);
      mem_done = 1'b1; mem_rdata = 64'h100 + 64'(t);
      applyStimulus();
      mem_done = 1'b0;
    end
    icache_ram_ren = 1'b0; dcache_req = 1'b0;
    applyStimulus();

    // Stray mem_done while idle
    mem_done = 1'b1;
    #1 checkOutput("idle done valid", icache_data_valid, 0);
    checkOutput("idle done ready", dcache_ready, 0);
    applyStimulus();
    mem_done = 1'b0;
    checkOutput("idle done busy", arb_busy, 0);

    // Reset during a dcache read, then a tie must go to icache
    dcache_req = 1'b1; dcache_addr = 32'h8000_3000;
    applyStimulus();
    checkOutput("rst.busy before", arb_busy, 1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst.mem_req", mem_req, 0);
    checkOutput("rst.arb_busy", arb_busy, 0);
    checkOutput("rst.dcache_ready", dcache_ready, 0);
    rst = 1'b0; icache_ram_ren = 1'b1; icache_ram_raddr = 32'h8000_0200;
    applyStimulus();
    checkOutput("rst.tie to icache", mem_addr, 64'h8000_0200);
    mem_done = 1'b1;
    applyStimulus();
    mem_done = 1'b0; icache_ram_ren = 1'b0; dcache_req = 1'b0;
    applyStimulus();
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
# ysyx_22040759_mem_arbiter

Two-requester arbiter that shares the single core-side memory port between the instruction-cache refill path and the data-cache/LSU path. It sits between the icache/dcache miss interfaces and the memory bridge (AXI master adapter). It grants one whole transaction at a time, holds the grant until the memory side signals completion, and uses round-robin priority on simultaneous requests so neither side starves.

## Interface
- AW, 32, address width
- DW, 64, data width (one beat per transaction)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_ram_ren  in  1  icache read request, level, held until icache_data_valid
- icache_ram_raddr  in  AW  icache read address (8-byte aligned)
- ram_icache_rdata  out  DW  read data to icache
- icache_data_valid  out  1  one-cycle completion pulse to icache
- dcache_req  in  1  dcache request, level, held until dcache_ready
- dcache_wen  in  1  1 = write, 0 = read
- dcache_addr  in  AW  dcache address
- dcache_wdata  in  DW  write data
- dcache_wmask  in  DW/8  byte write strobes
- dcache_rdata  out  DW  read data to dcache
- dcache_ready  out  1  one-cycle completion pulse to dcache
- mem_req  out  1  request to memory bridge, held until mem_done
- mem_wen  out  1  write when 1
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_wmask  out  DW/8  byte strobes
- mem_rdata  in  DW  read data, valid with mem_done
- mem_done  in  1  one-cycle completion pulse from bridge
- arb_busy  out  1  1 while a grant is held

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE: requests sampled only here. Only icache_ram_ren -> IBUSY. Only dcache_req -> DBUSY. Both -> grant the side not in last_grant; update last_grant to the winner. Neither -> stay.
- last_grant: 1-bit register, reset = DCACHE, so the first tie goes to icache.
- IBUSY: mem_req=1, mem_wen=0, mem_addr=icache_ram_raddr, mem_wdata=0, mem_wmask=0.
- DBUSY: mem_req=1, mem_wen=dcache_wen, mem_addr=dcache_addr, mem_wdata=dcache_wdata, mem_wmask=dcache_wmask.
- IDLE: all mem_* outputs 0.
- mem_done in IBUSY -> icache_data_valid=1, ram_icache_rdata=mem_rdata that cycle; next state IDLE. DBUSY: same via dcache_ready/dcache_rdata (rdata forwarded also on writes; dcache ignores it).
- Read data outputs are 0 whenever the matching valid/ready is 0.
- mem_done in IDLE: ignored, no pulse to either requester.
- Requester dropping its request while granted: grant still held until mem_done; completion pulse still issued.
- Address/data forwarded combinationally from the granted requester; requesters hold them stable while requesting.
- arb_busy = (state != IDLE).

## Timing
- Reset: state IDLE, last_grant DCACHE; mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, icache_data_valid, dcache_ready, both rdata, arb_busy all 0.
- Request seen in IDLE at cycle N -> mem_req high from cycle N+1.
- mem_done is accepted no earlier than N+1 and is passed through combinationally, so completion pulse is in the same cycle.
- After mem_done, state is IDLE at the next cycle. Earliest next grant: mem_req again one cycle later. There is a mandatory single IDLE cycle between transactions.
- Minimum request-to-completion: 1 cycle. No upper bound; no timeout.
- Reset mid-transaction: next cycle IDLE, mem_req 0, no completion pulse. The bridge must drop the outstanding transaction on the same rst.

## Test plan
- Reset, then icache_ram_ren=1 with addr 0x8000_0008 -> mem_req=1, mem_wen=0, mem_addr=0x8000_0008 at next cycle. mem_done with rdata 0x0000_0013_0000_0093 after 3 cycles -> icache_data_valid pulse with that data; state IDLE next cycle.
- dcache write at addr 0x8000_1000, wdata 0xDEAD_BEEF_0000_0001, wmask 0x0F -> mem_wen=1 with identical address, data and mask; dcache_ready pulses on mem_done; icache_data_valid stays 0.
- Both requests asserted continuously for 4 transactions -> grant order I, D, I, D. Each grant is separated by exactly one IDLE cycle.
- mem_done pulsed while IDLE -> no valid/ready pulse; state unchanged.
- rst asserted while in DBUSY before mem_done -> next cycle mem_req=0, arb_busy=0, no dcache_ready; the first tie after reset is granted to icache.
